// File: rtl/dmem_pkg.sv
// Shared defaults and state encoding for the data-memory load/store requester.
package dmem_pkg;
  localparam int AW_DEF = 4;
  localparam int DW_DEF = 4;
  localparam int LW_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RSP,
    S_ACK
  } lsu_state_t;
endpackage

// File: rtl/dmem_lsu.sv
// Load/fill burst requester driving the data memory port; returns load beats
// or a single store ack over a valid/ready response channel.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [LW-1:0] req_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  lsu_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_last_q, rsp_last_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      rsp_data_q <= rsp_data_d;
      rsp_last_q <= rsp_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = req_len;
          write_d = req_write;
          state_d = req_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + AW'(1);
        cnt_d  = cnt_q - LW'(1);
        if (cnt_q == '0) state_d = S_ACK;
      end
      S_READ: begin
        rsp_data_d = mem_rdata;
        rsp_last_d = (cnt_q == '0);
        state_d    = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          if (rsp_last_q) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + AW'(1);
            cnt_d   = cnt_q - LW'(1);
            state_d = S_READ;
          end
        end
      end
      S_ACK: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from registered state only, so no req/rsp input reaches them.
  assign req_ready = (state_q == S_IDLE);
  assign mem_write = (state_q == S_WRITE) && write_q;
  assign mem_read  = (state_q == S_READ);
  assign mem_addr  = (state_q == S_WRITE || state_q == S_READ) ? addr_q : '0;
  assign mem_wdata = (state_q == S_WRITE) ? wdata_q : '0;
  assign rsp_valid = (state_q == S_RSP) || (state_q == S_ACK);
  assign rsp_data  = (state_q == S_RSP) ? rsp_data_q : '0;
  assign rsp_last  = (state_q == S_RSP) ? rsp_last_q : (state_q == S_ACK);

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural 16x4 data memory responder
// and a response scoreboard.
module tb_dmem_lsu;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [3:0] req_addr = '0;
  logic [3:0] req_wdata = '0;
  logic [1:0] req_len = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic       rsp_last;
  logic       mem_write;
  logic       mem_read;
  logic [3:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;

  logic       mem_clr = 1'b0;
  logic [3:0] mem [16];
  logic [4:0] sb [$];
  logic [3:0] wlog [$];
  int         checks = 0;
  int         errors = 0;

  dmem_lsu dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge mem_clr) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop and write log, sampled mid-cycle.
  always @(negedge clk) begin
    logic [4:0] e;
    if (!reset && mem_write) wlog.push_back(mem_addr);
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(e[3:0]));
        chk("rsp_last", 32'(rsp_last), 32'(e[4]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [3:0] a, input logic [3:0] d,
                      input logic [1:0] l);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_len = l;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin tick(); n++; end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [3:0] held;
    int n;
    mem_clr = 1'b1;
    #1;
    mem_clr = 1'b0;
    // Reset values
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Wrapping fill 14..1 with 4'hA
    send(1'b1, 4'd14, 4'hA, 2'd3);
    chk("fill_b0_we", 32'(mem_write), 32'd1);
    chk("fill_b0_addr", 32'(mem_addr), 32'd14);
    chk("fill_b0_wdata", 32'(mem_wdata), 32'hA);
    chk("fill_req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("fill_b1_addr", 32'(mem_addr), 32'd15);
    tick();
    chk("fill_b2_addr", 32'(mem_addr), 32'd0);
    tick();
    chk("fill_b3_addr", 32'(mem_addr), 32'd1);
    chk("fill_b3_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("ack_valid", 32'(rsp_valid), 32'd1);
    chk("ack_data", 32'(rsp_data), 32'd0);
    chk("ack_last", 32'(rsp_last), 32'd1);
    chk("ack_no_write", 32'(mem_write), 32'd0);
    tick();
    chk("ack_stall_valid", 32'(rsp_valid), 32'd1);
    sb.push_back({1'b1, 4'h0});
    rsp_ready = 1'b1;
    drain();
    rsp_ready = 1'b0;
    chk("fill_nwrites", 32'(wlog.size()), 32'd4);
    chk("fill_m14", 32'(mem[14]), 32'hA);
    chk("fill_m15", 32'(mem[15]), 32'hA);
    chk("fill_m0", 32'(mem[0]), 32'hA);
    chk("fill_m1", 32'(mem[1]), 32'hA);
    chk("fill_m2", 32'(mem[2]), 32'h0);

    // Burst load with a 3-cycle stall on beat 2
    for (int i = 0; i < 3; i++) sb.push_back({1'b0, 4'hA});
    sb.push_back({1'b1, 4'hA});
    rsp_ready = 1'b1;
    send(1'b0, 4'd14, 4'h0, 2'd3);
    chk("ld_b0_read", 32'(mem_read), 32'd1);
    chk("ld_b0_addr", 32'(mem_addr), 32'd14);
    tick();
    chk("ld_b0_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();
    chk("ld_b1_addr", 32'(mem_addr), 32'd15);
    tick();
    rsp_ready = 1'b0;
    held = rsp_data;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", 32'(rsp_data), 32'(held));
      chk("stall_no_read", 32'(mem_read), 32'd0);
    end
    rsp_ready = 1'b1;
    drain();
    tick();
    chk("ld_done_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b0;

    // Single store then single load
    sb.push_back({1'b1, 4'h0});
    rsp_ready = 1'b1;
    send(1'b1, 4'd5, 4'd3, 2'd0);
    drain();
    tick();
    sb.push_back({1'b1, 4'h3});
    send(1'b0, 4'd5, 4'd0, 2'd0);
    chk("single_ld_not_yet", 32'(rsp_valid), 32'd0);
    tick();
    chk("single_ld_valid", 32'(rsp_valid), 32'd1);
    chk("single_ld_data", 32'(rsp_data), 32'd3);
    chk("single_ld_last", 32'(rsp_last), 32'd1);
    tick();
    chk("single_ld_sb", 32'(sb.size()), 32'd0);
    rsp_ready = 1'b0;

    // Reset after 2 of 4 fill beats
    wlog.delete();
    send(1'b1, 4'd8, 4'd5, 2'd3);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_write", 32'(mem_write), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_nwrites", 32'(wlog.size()), 32'd2);
    chk("mid_rst_m8", 32'(mem[8]), 32'd5);
    chk("mid_rst_m9", 32'(mem[9]), 32'd5);
    chk("mid_rst_m10", 32'(mem[10]), 32'd0);
    chk("mid_rst_m11", 32'(mem[11]), 32'd0);
    chk("mid_rst_no_ack", 32'(rsp_valid), 32'd0);
    sb.push_back({1'b1, 4'h0});
    rsp_ready = 1'b1;
    send(1'b1, 4'd10, 4'd7, 2'd0);
    drain();
    chk("post_rst_m10", 32'(mem[10]), 32'd7);
    rsp_ready = 1'b0;
    tick();

    // Request held during a busy burst
    wlog.delete();
    sb.push_back({1'b0, 4'hA});
    sb.push_back({1'b1, 4'hA});
    sb.push_back({1'b1, 4'h0});
    send(1'b0, 4'd14, 4'd0, 2'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd3; req_wdata = 4'd9; req_len = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_ready", 32'(req_ready), 32'd0);
    end
    chk("busy_no_write", 32'(wlog.size()), 32'd0);
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("busy_release", 32'(n < 50), 32'd1);
    chk("busy_sb_beats", 32'(sb.size()), 32'd1);
    chk("busy_m3_before", 32'(mem[3]), 32'd0);
    tick();
    req_valid = 1'b0;
    chk("busy_accepted", 32'(mem_write), 32'd1);
    chk("busy_addr", 32'(mem_addr), 32'd3);
    drain();
    chk("busy_m3_after", 32'(mem[3]), 32'd9);
    chk("busy_nwrites", 32'(wlog.size()), 32'd1);
    rsp_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
